// File: rtl/game_round_ctrl_if.sv
// game_round_ctrl_if: score transmit handshake and rival-score receive strobe between controller and UART.
interface game_round_ctrl_if #(parameter int SCORE_W = 8);
  logic               tx_valid;
  logic               tx_ready;
  logic [SCORE_W-1:0] my_score;
  logic               rival_valid;
  logic [SCORE_W-1:0] rival_score;
  modport master (output tx_valid, my_score, input tx_ready, rival_valid, rival_score);
  modport slave  (input tx_valid, my_score, output tx_ready, rival_valid, rival_score);
endinterface

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: multi-round game-flow controller; optional GAME_TIMER_EN ends GAME after GAME_CYCLES cycles.
module game_round_ctrl #(
  parameter int SCORE_W     = 8,
  parameter int ROUNDS      = 3,
  parameter int GAME_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_btn,
  input  logic                      hit_btn,
  input  logic                      stop_btn,
  input  logic                      ack_btn,
  input  logic                      start_sig,
  game_round_ctrl_if.master         uart,
  output logic [$clog2(ROUNDS):0]   round_idx,
  output logic                      led_win,
  output logic                      led_lose,
  output logic                      led_draw,
  output logic                      match_done,
  output logic                      match_win,
  output logic [2:0]                state_out
);
  localparam int RW = $clog2(ROUNDS) + 1;
  localparam int WW = $clog2(ROUNDS + 1);
  typedef enum logic [2:0] {IDLE, WAIT, GAME, SEND, RECV, RESULT} state_t;
  state_t             state, state_nx;
  logic [SCORE_W-1:0] rival_reg;
  logic               pending;
  logic [WW-1:0]      my_wins, rival_wins;
  logic               stop, last;
`ifdef GAME_TIMER_EN
  localparam int TW = GAME_CYCLES > 1 ? $clog2(GAME_CYCLES) : 1;
  logic [TW-1:0] timer;
  always_ff @(posedge clk or posedge rst)
    if (rst) timer <= '0;
    else     timer <= state == GAME ? timer + 1'b1 : '0;
  assign stop = stop_btn | (timer == TW'(GAME_CYCLES - 1));
`else
  assign stop = stop_btn;
`endif
  assign last      = round_idx == RW'(ROUNDS - 1);
  assign state_out = state;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = start_btn ? WAIT : IDLE;
      WAIT:    state_nx = start_sig ? GAME : WAIT;
      GAME:    state_nx = stop ? SEND : GAME;
      SEND:    state_nx = uart.tx_ready ? RECV : SEND;
      RECV:    state_nx = pending ? RESULT : RECV;
      RESULT:  state_nx = ack_btn ? (last ? IDLE : WAIT) : RESULT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      uart.tx_valid <= 1'b0;
      uart.my_score <= '0;
      round_idx     <= '0;
      {led_win, led_lose, led_draw} <= '0;
      match_done    <= 1'b0;
      match_win     <= 1'b0;
      rival_reg     <= '0;
      pending       <= 1'b0;
      my_wins       <= '0;
      rival_wins    <= '0;
    end else begin
      match_done    <= 1'b0;
      uart.tx_valid <= state_nx == SEND;
      // a fresh strobe outranks consumption so the newest rival score is never lost
      if (state != IDLE && uart.rival_valid) begin
        rival_reg <= uart.rival_score;
        pending   <= 1'b1;
      end else if (state == RECV) pending <= 1'b0;
      case (state)
        IDLE: if (start_btn) begin
          uart.my_score <= '0;
          round_idx     <= '0;
          my_wins       <= '0;
          rival_wins    <= '0;
          {led_win, led_lose, led_draw} <= '0;
          match_win     <= 1'b0;
        end
        GAME: if (hit_btn && uart.my_score != '1) uart.my_score <= uart.my_score + 1'b1;
        RECV: if (pending) begin
          led_win    <= uart.my_score > rival_reg;
          led_lose   <= uart.my_score < rival_reg;
          led_draw   <= uart.my_score == rival_reg;
          my_wins    <= my_wins + WW'(uart.my_score > rival_reg);
          rival_wins <= rival_wins + WW'(uart.my_score < rival_reg);
        end
        RESULT: if (ack_btn) begin
          if (last) begin
            match_done <= 1'b1;
            match_win  <= my_wins > rival_wins;
          end else begin
            round_idx     <= round_idx + 1'b1;
            uart.my_score <= '0;
            {led_win, led_lose, led_draw} <= '0;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: directed and randomized match play against a round-level score/outcome model.
module tb_game_round_ctrl;
  localparam int SW = 4, RN = 3, GC = 16;
`ifdef GAME_TIMER_EN
  localparam int NHMAX = 14;
`else
  localparam int NHMAX = 20;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic start_btn = 0, hit_btn = 0, stop_btn = 0, ack_btn = 0, start_sig = 0;
  logic [$clog2(RN):0] round_idx;
  logic led_win, led_lose, led_draw, match_done, match_win;
  logic [2:0] state_out;
  int checks = 0, errors = 0;
  int rnd, my_w, riv_w;
  game_round_ctrl_if #(.SCORE_W(SW)) uart ();
  game_round_ctrl #(.SCORE_W(SW), .ROUNDS(RN), .GAME_CYCLES(GC)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .hit_btn(hit_btn), .stop_btn(stop_btn),
    .ack_btn(ack_btn), .start_sig(start_sig), .uart(uart), .round_idx(round_idx),
    .led_win(led_win), .led_lose(led_lose), .led_draw(led_draw), .match_done(match_done),
    .match_win(match_win), .state_out(state_out));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic strobe(input int rv);
    uart.rival_score = SW'(rv);
    uart.rival_valid = 1'b1;
    tick;
    uart.rival_valid = 1'b0;
  endtask
  task automatic start_match;
    chk("idle_before_start", 32'(state_out), 0);
    start_btn = 1'b1;
    tick;
    start_btn = 1'b0;
    chk("start_clears_match_win", 32'(match_win), 0);
    my_w = 0;
    riv_w = 0;
    rnd = 0;
  endtask
  task automatic finish_round(input int sc, input int rv);
    chk("led_win", 32'(led_win), 32'(sc > rv));
    chk("led_lose", 32'(led_lose), 32'(sc < rv));
    chk("led_draw", 32'(led_draw), 32'(sc == rv));
    my_w += int'(sc > rv);
    riv_w += int'(sc < rv);
    tick;
    chk("result_hold", 32'({led_win, led_lose, led_draw, state_out}), 32'({sc > rv, sc < rv, sc == rv, 3'd5}));
    ack_btn = 1'b1;
    tick;
    ack_btn = 1'b0;
    if (rnd == RN - 1) begin
      chk("match_done_pulse", 32'(match_done), 1);
      chk("match_win", 32'(match_win), 32'(my_w > riv_w));
      chk("end_idle", 32'(state_out), 0);
      tick;
      chk("match_done_one_cycle", 32'(match_done), 0);
      chk("match_win_held", 32'(match_win), 32'(my_w > riv_w));
    end else begin
      chk("next_wait", 32'(state_out), 1);
      chk("next_round_idx", 32'(round_idx), rnd + 1);
      chk("next_score_clear", 32'(uart.my_score), 0);
      chk("next_leds_clear", 32'({led_win, led_lose, led_draw}), 0);
    end
    rnd++;
  endtask
  task automatic play(input int nh, input int rv, input bit early, input int dly);
    int sc, k;
    sc = nh > 15 ? 15 : nh;
    chk("wait_state", 32'(state_out), 1);
    chk("round_idx", 32'(round_idx), rnd);
    uart.tx_ready = 1'b1;
    tick;
    uart.tx_ready = 1'b0;
    chk("ready_ignored_in_wait", 32'({uart.tx_valid, state_out}), 1);
    start_sig = 1'b1;
    tick;
    start_sig = 1'b0;
    chk("game_state", 32'(state_out), 2);
    if (early) strobe(rv);
    if (nh > 1) begin
      hit_btn = 1'b1;
      repeat (nh - 1) tick;
    end
    hit_btn = nh > 0;
    stop_btn = 1'b1;
    tick;
    hit_btn = 1'b0;
    stop_btn = 1'b0;
    chk("send_state", 32'(state_out), 3);
    chk("send_valid", 32'(uart.tx_valid), 1);
    chk("send_score", 32'(uart.my_score), sc);
    hit_btn = 1'b1;
    repeat (dly) tick;
    hit_btn = 1'b0;
    chk("send_hold", 32'({uart.tx_valid, state_out, uart.my_score}), 32'({1'b1, 3'd3, SW'(sc)}));
    uart.tx_ready = 1'b1;
    tick;
    uart.tx_ready = 1'b0;
    chk("recv_state", 32'(state_out), 4);
    chk("valid_drops", 32'(uart.tx_valid), 0);
    if (!early) begin
      repeat (2) tick;
      chk("recv_waits_for_strobe", 32'(state_out), 4);
      strobe(rv);
    end
    k = 0;
    while (state_out != 3'd5 && k < 5) begin
      tick;
      k++;
    end
    chk("recv_latency", 32'(k), 1);
    finish_round(sc, rv);
  endtask
  initial begin
    uart.tx_ready = 1'b0;
    uart.rival_valid = 1'b0;
    uart.rival_score = '0;
    repeat (2) tick;
    chk("rst_state", 32'(state_out), 0);
    chk("rst_outputs", 32'({uart.tx_valid, uart.my_score, round_idx, led_win, led_lose, led_draw, match_done, match_win}), 0);
    rst = 1'b0;
    tick;
    start_btn = 1'b1;
    tick;
    start_btn = 1'b0;
    start_sig = 1'b1;
    tick;
    start_sig = 1'b0;
    hit_btn = 1'b1;
    repeat (2) tick;
    hit_btn = 1'b0;
    stop_btn = 1'b1;
    tick;
    stop_btn = 1'b0;
    chk("pre_rst_send", 32'({uart.tx_valid, state_out, uart.my_score}), 32'({1'b1, 3'd3, SW'(2)}));
    #2 rst = 1'b1;
    #1 chk("async_rst", 32'({uart.tx_valid, state_out, uart.my_score}), 0);
    tick;
    rst = 1'b0;
    tick;
    strobe(9);
    hit_btn = 1'b1;
    tick;
    hit_btn = 1'b0;
    chk("idle_ignores_inputs", 32'({state_out, uart.my_score}), 0);
    start_match;
    play(5, 3, 1'b0, 0);
    play(2, 9, 1'b1, 3);
    play(0, 1, 1'b0, 10);
    start_match;
`ifdef GAME_TIMER_EN
    begin
      int k;
      start_sig = 1'b1;
      tick;
      start_sig = 1'b0;
      hit_btn = 1'b1;
      k = 0;
      while (state_out == 3'd2 && k < 40) begin
        tick;
        k++;
      end
      hit_btn = 1'b0;
      chk("timer_cycles", 32'(k), GC);
      chk("timer_saturate", 32'(uart.my_score), 15);
      uart.tx_ready = 1'b1;
      tick;
      uart.tx_ready = 1'b0;
      strobe(15);
      tick;
      finish_round(15, 15);
    end
`else
    play(20, 15, 1'b1, 1);
`endif
    play(int'($urandom_range(0, NHMAX)), int'($urandom_range(0, 15)), 1'b0, 2);
    play(int'($urandom_range(0, NHMAX)), int'($urandom_range(0, 15)), 1'b1, 0);
    repeat (4) begin
      start_match;
      repeat (RN) play(int'($urandom_range(0, NHMAX)), int'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
